// File: rtl/pc_fetch_ctrl.sv
// Fetch-stage sequencer: owns the PC and drives the instruction-memory handshake.
// It registers fetched words for decode, holds one word in a skid buffer while decode stalls, and drops responses from wrong-path fetches.
module pc_fetch_ctrl #(
  parameter logic [29:0] RESET_ADDR = 30'h0000000
) (
  input  logic        i_clk,
  input  logic        i_rst,
  input  logic        i_stall,
  input  logic        i_PCSrc,
  input  logic [29:0] i_targ_addr,
  output logic        o_imem_req,
  output logic [29:0] o_imem_addr,
  input  logic        i_imem_ack,
  input  logic [31:0] i_imem_rdata,
  output logic [31:0] o_instr,
  output logic        o_instr_valid,
  output logic [29:0] o_incPC,
  output logic        o_flush
);

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_WAIT  = 2'd1,
    ST_FULL  = 2'd2,
    ST_DRAIN = 2'd3
  } state_t;

  state_t      state_r, state_s;
  logic [29:0] pc_r, pc_s;
  logic [29:0] addr_r, addr_s;
  logic        req_r, req_s;
  logic [31:0] skid_r, skid_s;
  logic [29:0] skid_inc_r, skid_inc_s;
  logic [31:0] instr_r, instr_s;
  logic        instr_valid_r, instr_valid_s;
  logic [29:0] inc_pc_r, inc_pc_s;
  logic        slot_free_s;
  logic [29:0] pc_inc_s;

  assign slot_free_s = !instr_valid_r || !i_stall;
  assign pc_inc_s    = pc_r + 30'd1;

  // Next-state, PC, skid-buffer and output-register update logic
  always_comb begin
    state_s       = state_r;
    pc_s          = pc_r;
    skid_s        = skid_r;
    skid_inc_s    = skid_inc_r;
    instr_s       = instr_r;
    inc_pc_s      = inc_pc_r;
    if (i_stall) begin
      instr_valid_s = instr_valid_r;
    end else begin
      instr_valid_s = 1'b0;
    end

    if (i_PCSrc) begin
      // Redirect wins over stall and ack; an in-flight request must still be drained
      pc_s          = i_targ_addr;
      instr_valid_s = 1'b0;
      skid_s        = 32'd0;
      skid_inc_s    = 30'd0;
      case (state_r)
        ST_WAIT: begin
          if (i_imem_ack) begin
            state_s = ST_IDLE;
          end else begin
            state_s = ST_DRAIN;
          end
        end
        ST_DRAIN: state_s = ST_DRAIN;
        default:  state_s = ST_IDLE;
      endcase
    end else begin
      case (state_r)
        ST_IDLE: begin
          if (slot_free_s) begin
            state_s = ST_WAIT;
          end else begin
            state_s = ST_IDLE;
          end
        end
        ST_WAIT: begin
          if (i_imem_ack && slot_free_s) begin
            instr_s       = i_imem_rdata;
            instr_valid_s = 1'b1;
            inc_pc_s      = pc_inc_s;
            pc_s          = pc_inc_s;
          end else if (i_imem_ack) begin
            skid_s     = i_imem_rdata;
            skid_inc_s = pc_inc_s;
            pc_s       = pc_inc_s;
            state_s    = ST_FULL;
          end else begin
            state_s = ST_WAIT;
          end
        end
        ST_FULL: begin
          if (!i_stall) begin
            instr_s       = skid_r;
            inc_pc_s      = skid_inc_r;
            instr_valid_s = 1'b1;
            state_s       = ST_IDLE;
          end else begin
            state_s = ST_FULL;
          end
        end
        ST_DRAIN: begin
          if (i_imem_ack) begin
            state_s = ST_IDLE;
          end else begin
            state_s = ST_DRAIN;
          end
        end
        default: state_s = ST_IDLE;
      endcase
    end

    // The request address only moves when a fresh request starts; DRAIN keeps the old one
    if (state_s == ST_WAIT) begin
      addr_s = pc_s;
    end else begin
      addr_s = addr_r;
    end
    req_s = (state_s == ST_WAIT) || (state_s == ST_DRAIN);
  end

  // State and registered-output update with synchronous reset
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state_r       <= ST_IDLE;
      pc_r          <= RESET_ADDR;
      addr_r        <= RESET_ADDR;
      req_r         <= 1'b0;
      skid_r        <= 32'd0;
      skid_inc_r    <= 30'd0;
      instr_r       <= 32'd0;
      instr_valid_r <= 1'b0;
      inc_pc_r      <= 30'd0;
    end else begin
      state_r       <= state_s;
      pc_r          <= pc_s;
      addr_r        <= addr_s;
      req_r         <= req_s;
      skid_r        <= skid_s;
      skid_inc_r    <= skid_inc_s;
      instr_r       <= instr_s;
      instr_valid_r <= instr_valid_s;
      inc_pc_r      <= inc_pc_s;
    end
  end

  assign o_imem_req    = req_r;
  assign o_imem_addr   = addr_r;
  assign o_instr       = instr_r;
  assign o_instr_valid = instr_valid_r;
  assign o_incPC       = inc_pc_r;
  assign o_flush       = i_PCSrc;

endmodule

// File: doc/pc_fetch_ctrl.md
Name: pc_fetch_ctrl

Overview:
- Fetch-stage sequencer that owns the program counter and drives the instruction-memory request handshake.
- Delivers each fetched instruction with its word-address PC+1, for the next-PC adder's incPC input.
- Accepts the resolved redirect (PCSrc plus 30-bit target) from the next-PC logic and flushes wrong-path fetches.
- Absorbs downstream stalls with a one-entry skid buffer so no fetched word is lost.

Parameters:
- RESET_ADDR, 30'h0000000, word address of the first fetch after reset.

Ports:
- i_clk  input  1  clock; all state updates on the rising edge.
- i_rst  input  1  synchronous, active-high reset.
- i_stall  input  1  decode stage cannot accept this cycle; o_instr/o_instr_valid/o_incPC must hold.
- i_PCSrc  input  1  redirect strobe: take i_targ_addr.
- i_targ_addr  input  30  redirect target word address.
- o_imem_req  output  1  instruction memory request.
- o_imem_addr  output  30  request word address; stable while o_imem_req=1 and i_imem_ack=0.
- i_imem_ack  input  1  request complete; i_imem_rdata valid in the same cycle.
- i_imem_rdata  input  32  instruction word.
- o_instr  output  32  instruction to decode.
- o_instr_valid  output  1  o_instr is a valid, non-flushed instruction.
- o_incPC  output  30  PC+1 of o_instr, modulo 2^30.
- o_flush  output  1  combinational copy of i_PCSrc; decode/IF-ID register kill.

Behaviour:
- Reset (i_rst=1 at an edge):
  - pc=RESET_ADDR, state=IDLE.
  - o_imem_req=0, o_instr_valid=0, o_instr=0, o_incPC=0, skid empty.
  - Reset overrides everything, including mid-request; memory tolerates an abandoned request.
- Internal signal: slot_free = !o_instr_valid | !i_stall.
- States:
  - IDLE: req=0.
  - WAIT: req=1, addr=pc.
  - FULL: req=0, skid holds a word.
  - DRAIN: req=1, addr=old pc, response will be discarded.
- Redirect (i_PCSrc=1) has priority over stall and ack in every state:
  - pc<=i_targ_addr.
  - o_instr_valid<=0 and skid cleared at the next edge.
  - Transitions: IDLE->IDLE; FULL->IDLE; WAIT with ack->IDLE, data dropped; WAIT without ack->DRAIN.
  - DRAIN: stays DRAIN, pc updated to the newest target.
- IDLE: slot_free -> WAIT, else stay.
- WAIT, no ack: hold; o_imem_addr must not change.
- WAIT, ack, slot_free:
  - o_instr<=rdata, o_instr_valid<=1, o_incPC<=pc+1, pc<=pc+1.
  - Stay WAIT; the next request is issued the following cycle.
  - Sustained throughput is 1 instruction/cycle with a zero-wait memory.
- WAIT, ack, !slot_free:
  - skid<=rdata, skid_inc<=pc+1, pc<=pc+1 -> FULL.
- FULL, !i_stall:
  - o_instr<=skid, o_incPC<=skid_inc, o_instr_valid<=1 -> IDLE.
- DRAIN, ack: discard rdata -> IDLE. No ack: hold req and old addr.
- Output register when no new word is loaded:
  - !i_stall: o_instr_valid<=0; o_instr/o_incPC may keep stale values.
  - i_stall: hold all outputs.
- Arithmetic: pc+1 in 30 bits, 30'h3FFFFFFF wraps to 30'h0000000.
- Latency: first req one cycle after reset release; fetch-to-o_instr_valid is one edge after ack.
- Redirect to first target request:
  - Without an outstanding request: one cycle (IDLE->WAIT).
  - With an outstanding request: the old ack plus one cycle.

Test Plan:
- Reset RESET_ADDR=30'h100, ack always 1, no stall -> req high from cycle 1; addrs 100, 101, 102; o_incPC 101, 102, 103; valid every cycle.
- Stall 3 cycles during streaming, ack=1 -> o_instr holds; exactly one extra word goes to the skid; no req while FULL; after release, words appear in order with no loss or duplicate.
- Redirect with i_targ_addr=30'h2000 while WAIT with ack delayed 2 cycles -> o_flush same cycle; o_imem_addr stays old until ack; that data is never valid; next req addr=30'h2000.
- Redirect in the same cycle as ack plus stall -> data dropped; FULL not entered; o_instr_valid=0 next cycle; next fetch at target.
- pc=30'h3FFFFFFF fetch -> o_incPC=0; next addr 0.
- i_rst asserted mid-WAIT -> req=0 and valid=0 next cycle; restarts at RESET_ADDR.
